// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer for the 8-bit MIPS core.
// Optional sticky PC-wrap trap is enabled by defining PC_WRAP_TRAP_EN.
module pc_fetch_unit #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          INSTR_W  = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    next_pc,
    input  logic                 pc_load,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic [INSTR_W-1:0]   instr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [ADDR_W-1:0]    pc_out,
    output logic                 wrap_trap
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic               wrap_set;
    logic               fetch_suppressed;

    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef PC_WRAP_TRAP_EN
    logic wrap_trap_q, wrap_trap_d;

    // Trap fires only on a sequential advance out of the all-ones PC.
    assign wrap_set         = (state_q == ST_HOLD) && !pc_load && instr_ready
                              && (pc_q == {ADDR_W{1'b1}});
    assign fetch_suppressed = wrap_trap_q;

    always_comb begin
        wrap_trap_d = wrap_trap_q;
        if (wrap_set) begin
            wrap_trap_d = 1'b1;
        end else if ((state_q == ST_IDLE) && pc_load) begin
            wrap_trap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_trap_q <= 1'b0;
        end else begin
            wrap_trap_q <= wrap_trap_d;
        end
    end

    assign wrap_trap = wrap_trap_q;
`else
    assign wrap_set         = 1'b0;
    assign fetch_suppressed = 1'b0;
    assign wrap_trap        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        instr_d      = instr_q;
        case (state_q)
            ST_IDLE: begin
                if (pc_load) begin
                    pc_d         = next_pc;
                    fetch_addr_d = next_pc;
                    state_d      = ST_FETCH;
                end else if (!fetch_suppressed) begin
                    fetch_addr_d = pc_q;
                    state_d      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (imem_ack && !pc_load) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end else if (imem_ack) begin
                    pc_d         = next_pc;
                    fetch_addr_d = next_pc;
                end else if (pc_load) begin
                    // The memory may still be looking at the old address, so keep it stable.
                    pc_d    = next_pc;
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (pc_load) begin
                    pc_d = next_pc;
                end
                if (imem_ack) begin
                    fetch_addr_d = pc_load ? next_pc : pc_q;
                    state_d      = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (pc_load) begin
                    pc_d         = next_pc;
                    fetch_addr_d = next_pc;
                    state_d      = ST_FETCH;
                end else if (instr_ready) begin
                    if (wrap_set) begin
                        state_d = ST_IDLE;
                    end else begin
                        pc_d         = pc_inc;
                        fetch_addr_d = pc_inc;
                        state_d      = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            instr_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH) || (state_q == ST_DISCARD);
    assign imem_addr   = fetch_addr_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == ST_HOLD);
    assign pc_out      = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a transaction-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_pc_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] next_pc;
    logic       pc_load;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc_out;
    logic       wrap_trap;

    int checks   = 0;
    int failures = 0;

`ifdef PC_WRAP_TRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    pc_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .pc_load     (pc_load),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .wrap_trap   (wrap_trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction view: an outstanding request (possibly stale), or a held instruction, or neither.
    logic [7:0] m_pc;
    logic [7:0] m_addr;
    logic [7:0] m_instr;
    bit         m_req;
    bit         m_stale;
    bit         m_valid;
    bit         m_wrap;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pc    = 8'h00;
        m_addr  = 8'h00;
        m_instr = 8'h00;
        m_req   = 0;
        m_stale = 0;
        m_valid = 0;
        m_wrap  = 0;
    endtask

    task automatic modelStep();
        logic [7:0] target;
        if (m_valid) begin
            if (pc_load) begin
                m_valid = 0;
                m_pc    = next_pc;
                m_addr  = next_pc;
                m_req   = 1;
            end else if (instr_ready) begin
                m_valid = 0;
                if (WRAP_EN && m_pc == 8'hFF) begin
                    m_wrap = 1;
                end else begin
                    m_pc   = 8'((int'(m_pc) + 1) % 256);
                    m_addr = m_pc;
                    m_req  = 1;
                end
            end
        end else if (m_req) begin
            if (imem_ack) begin
                if (!m_stale && !pc_load) begin
                    m_valid = 1;
                    m_instr = imem_rdata;
                    m_req   = 0;
                end else begin
                    target  = pc_load ? next_pc : m_pc;
                    m_pc    = target;
                    m_addr  = target;
                    m_stale = 0;
                end
            end else if (pc_load) begin
                m_pc    = next_pc;
                m_stale = 1;
            end
        end else begin
            if (pc_load) begin
                m_pc   = next_pc;
                m_addr = next_pc;
                m_req  = 1;
                m_wrap = 0;
            end else if (!m_wrap) begin
                m_addr = m_pc;
                m_req  = 1;
            end
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk);
            if (!rst_n) modelReset();
            else        modelStep();
            #1;
            checkOutput("cyc_imem_req",    imem_req,    m_req);
            checkOutput("cyc_imem_addr",   imem_addr,   m_addr);
            checkOutput("cyc_instr_valid", instr_valid, m_valid);
            checkOutput("cyc_instr",       instr,       m_instr);
            checkOutput("cyc_pc_out",      pc_out,      m_pc);
            checkOutput("cyc_wrap_trap",   wrap_trap,   m_wrap);
        end
    end

    // Inputs are applied at a falling edge and held across the next rising edge.
    task automatic applyStimulus(input bit load, input logic [7:0] npc, input bit ack,
                                 input logic [7:0] rdata, input bit ready);
        pc_load     = load;
        next_pc     = npc;
        imem_ack    = ack;
        imem_rdata  = rdata;
        instr_ready = ready;
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        pc_load     = 1'b0;
        next_pc     = 8'h00;
        imem_ack    = 1'b0;
        imem_rdata  = 8'h00;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_imem_req",    imem_req,    1'b0);
        checkOutput("rst_imem_addr",   imem_addr,   8'h00);
        checkOutput("rst_pc_out",      pc_out,      8'h00);
        checkOutput("rst_instr_valid", instr_valid, 1'b0);
        checkOutput("rst_instr",       instr,       8'h00);
        checkOutput("rst_wrap_trap",   wrap_trap,   1'b0);
        rst_n = 1'b1;

        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        checkOutput("first_req",  imem_req,  1'b1);
        checkOutput("first_addr", imem_addr, 8'h00);
        applyStimulus(0, 8'h00, 1, 8'h11, 1);
        checkOutput("i0_valid", instr_valid, 1'b1);
        checkOutput("i0_instr", instr,       8'h11);
        checkOutput("i0_pc",    pc_out,      8'h00);
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        checkOutput("second_addr", imem_addr,   8'h01);
        checkOutput("second_gap",  instr_valid, 1'b0);
        applyStimulus(0, 8'h00, 1, 8'h22, 1);
        checkOutput("i1_instr", instr,  8'h22);
        checkOutput("i1_pc",    pc_out, 8'h01);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 0, 8'h00, 0);
            checkOutput("stall_valid", instr_valid, 1'b1);
            checkOutput("stall_instr", instr,       8'h22);
            checkOutput("stall_pc",    pc_out,      8'h01);
            checkOutput("stall_req",   imem_req,    1'b0);
        end
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        checkOutput("adv_addr", imem_addr, 8'h02);

        applyStimulus(1, 8'h40, 0, 8'h00, 0);
        checkOutput("redir_addr_hold", imem_addr, 8'h02);
        checkOutput("redir_pc",        pc_out,    8'h40);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 8'h00, 0, 8'h00, 0);
            checkOutput("redir_wait_addr", imem_addr, 8'h02);
            checkOutput("redir_wait_req",  imem_req,  1'b1);
        end
        applyStimulus(0, 8'h00, 1, 8'h99, 0);
        checkOutput("stale_dropped", instr_valid, 1'b0);
        checkOutput("redir_new_addr", imem_addr,  8'h40);
        applyStimulus(0, 8'h00, 1, 8'h33, 0);
        checkOutput("redir_instr", instr,  8'h33);
        checkOutput("redir_pc_out", pc_out, 8'h40);

        applyStimulus(1, 8'h80, 0, 8'h00, 1);
        checkOutput("hold_load_addr",  imem_addr,   8'h80);
        checkOutput("hold_load_valid", instr_valid, 1'b0);

        applyStimulus(1, 8'h90, 1, 8'h55, 0);
        checkOutput("ackload_valid", instr_valid, 1'b0);
        checkOutput("ackload_addr",  imem_addr,   8'h90);
        checkOutput("ackload_req",   imem_req,    1'b1);
        applyStimulus(0, 8'h00, 1, 8'h66, 0);
        checkOutput("ackload_instr", instr,  8'h66);
        checkOutput("ackload_pc",    pc_out, 8'h90);

        applyStimulus(1, 8'hFF, 0, 8'h00, 0);
        applyStimulus(0, 8'h00, 1, 8'h77, 0);
        checkOutput("ff_pc", pc_out, 8'hFF);
        applyStimulus(0, 8'h00, 0, 8'h00, 1);
`ifdef PC_WRAP_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 8'h00, 0, 8'h00, 0);
            checkOutput("trap_flag", wrap_trap, 1'b1);
            checkOutput("trap_req",  imem_req,  1'b0);
        end
        applyStimulus(1, 8'h10, 0, 8'h00, 0);
        checkOutput("trap_clear", wrap_trap, 1'b0);
        checkOutput("trap_addr",  imem_addr, 8'h10);
        applyStimulus(0, 8'h00, 1, 8'h34, 0);
        checkOutput("trap_resume_pc", pc_out, 8'h10);
`else
        checkOutput("wrap_addr", imem_addr, 8'h00);
        checkOutput("wrap_pc",   pc_out,    8'h00);
        checkOutput("wrap_flag", wrap_trap, 1'b0);
        applyStimulus(0, 8'h00, 1, 8'h12, 0);
        checkOutput("wrap_instr", instr, 8'h12);
`endif

        applyStimulus(0, 8'h00, 0, 8'h00, 1);
        checkOutput("pre_rst_req", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req",  imem_req,  1'b0);
        checkOutput("midrst_addr", imem_addr, 8'h00);
        checkOutput("midrst_pc",   pc_out,    8'h00);
        pc_load     = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'h00, 0, 8'h00, 0);
        checkOutput("post_rst_addr", imem_addr, 8'h00);
        checkOutput("post_rst_req",  imem_req,  1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
